// File: rtl/mem_responder.sv
// Responder end of the CPU memory port: one valid/ready response per valid/ready
// request, backed by a word array with LATENCY wait states ahead of each access.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] WAIT_CYCLES = 4'(LATENCY);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [3:0]            count;
    logic                  accept;
    logic [29:0]           addr_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] index;
    logic [31:0]           mem [DEPTH];

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign in_range = (addr_q >> ADDR_WIDTH) == 30'd0;
    assign index    = addr_q[ADDR_WIDTH-1:0];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (LATENCY == 0) ? ACCESS : WAIT;
            WAIT:    if (count == 4'd1) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req_ready is registered from the next state, so it is low throughout reset
    // and rises on the first edge after release or after a response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            req_ready <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == IDLE);
            if (accept) begin
                count <= WAIT_CYCLES;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ACCESS: begin
                    resp_valid <= 1'b1;
                    resp_err   <= !in_range;
                    if (in_range && !we_q) begin
                        resp_rdata <= mem[index];
                    end else begin
                        resp_rdata <= 32'd0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= resp_valid;
                end
            endcase
        end
    end

    // The write is gated by the ACCESS state, which reset clears asynchronously,
    // so a transaction dropped before its access edge never touches the array.
    always_ff @(posedge clk) begin
        if (state == ACCESS && in_range && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem[index][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level reference model with
// per-cycle comparison, directed scenarios, randomized traffic, and a LATENCY=0 instance.
module tb_mem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        z_reset;
    logic        z_req_valid;
    logic        z_req_ready;
    logic [29:0] z_req_addr;
    logic        z_req_we;
    logic [31:0] z_req_wdata;
    logic [3:0]  z_req_wmask;
    logic        z_resp_valid;
    logic        z_resp_ready;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut_zero (
        .clk(clk), .reset(z_reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
        .req_we(z_req_we), .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction whose effect lands LAT+1 edges
    // after its accept edge; everything else is zero while no response is shown.
    logic [31:0] mem_m [0:1023];
    bit          m_out;
    bit          m_ready;
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_data;
    logic [29:0] p_addr;
    bit          p_we;
    logic [31:0] p_data;
    logic [3:0]  p_mask;
    int          due;

    always @(posedge clk) begin
        edges++;
        if (reset) begin
            m_out = 0; m_valid = 0; m_err = 0; m_data = 32'd0;
        end else if (m_valid && resp_ready) begin
            m_out = 0; m_valid = 0; m_err = 0; m_data = 32'd0;
        end else if (!m_out && m_ready && req_valid) begin
            m_out  = 1;
            p_addr = req_addr; p_we = req_we; p_data = req_wdata; p_mask = req_wmask;
            due    = edges + LAT + 1;
        end else if (m_out && !m_valid && edges == due) begin
            m_valid = 1;
            m_data  = 32'd0;
            m_err   = 0;
            if (p_addr >= 30'd1024) begin
                m_err = 1;
            end else if (p_we) begin
                for (int b = 0; b < 4; b++)
                    if (p_mask[b]) mem_m[p_addr][8*b +: 8] = p_data[8*b +: 8];
            end else begin
                m_data = mem_m[p_addr];
            end
        end
        m_ready = !reset && !m_out;
        #1;
        check("req_ready", req_ready, m_ready);
        check("resp_valid", resp_valid, m_valid);
        check("resp_rdata", resp_rdata, m_data);
        check("resp_err", resp_err, m_err);
    end

    task automatic issue(input logic [29:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m);
        int n = 0;
        req_valid = 1; req_addr = a; req_we = w; req_wdata = d; req_wmask = m;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        req_addr  = 30'($urandom);
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        req_wmask = 4'($urandom);
    endtask

    task automatic await_resp(input int bp, input bit fast, output logic [31:0] rd,
                              output logic er, output int lat);
        int k = 0;
        while (!resp_valid && k < 100) begin
            resp_ready = fast ? 1'b1 : (bp > 0 ? 1'b0 : 1'($urandom));
            @(negedge clk);
            k++;
        end
        lat = k;
        rd  = resp_rdata;
        er  = resp_err;
        for (int i = 0; i < bp; i++) begin
            resp_ready = 0;
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_rdata_stable", resp_rdata, rd);
        end
        k = 0;
        while (!req_ready && k < 100) begin
            resp_ready = (fast || bp > 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            k++;
        end
        if (bp > 0) check("bp_release_cycles", k, 1);
        check("resp_handshake", req_ready, 1);
    endtask

    task automatic xact(input logic [29:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] m, input int bp, input bit fast,
                        output logic [31:0] rd, output logic er, output int lat);
        issue(a, w, d, m);
        await_resp(bp, fast, rd, er, lat);
    endtask

    // Asserts reset a little after a falling edge and checks the outputs clear at once.
    task automatic apply_reset();
        #2 reset = 1;
        #1;
        check("async_resp_valid", resp_valid, 0);
        check("async_resp_rdata", resp_rdata, 0);
        check("async_resp_err", resp_err, 0);
        check("async_req_ready", req_ready, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          k;
        logic [31:0] init0;
        logic [31:0] d;

        reset = 1; req_valid = 0; req_addr = 0; req_we = 0; req_wdata = 0; req_wmask = 0;
        resp_ready = 0;
        z_reset = 1; z_req_valid = 0; z_req_addr = 0; z_req_we = 0; z_req_wdata = 0;
        z_req_wmask = 0; z_resp_ready = 0;
        init0 = 32'd0;

        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        for (int i = 0; i < 16; i++) begin
            d = (i == 7) ? 32'd0 : $urandom;
            if (i == 0) init0 = d;
            xact(30'(i), 1, d, 4'hF, 0, 1, rd, er, lat);
        end

        xact(30'd5, 1, 32'hDEADBEEF, 4'hF, 0, 1, rd, er, lat);
        check("wr5_latency", lat, 3);
        check("wr5_rdata", rd, 32'h0);
        check("wr5_err", er, 0);
        xact(30'd5, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("rd5_latency", lat, 3);
        check("rd5_rdata", rd, 32'hDEADBEEF);
        check("rd5_err", er, 0);

        xact(30'd9, 1, 32'h11223344, 4'hF, 0, 1, rd, er, lat);
        xact(30'd9, 1, 32'hAABBCCDD, 4'b0101, 0, 1, rd, er, lat);
        xact(30'd9, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("mask_rdata", rd, 32'h11BB33DD);

        xact(30'd5, 0, 32'h0, 4'h0, 10, 0, rd, er, lat);
        check("bp_rdata", rd, 32'hDEADBEEF);

        xact(30'h400, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("oor_read_err", er, 1);
        check("oor_read_rdata", rd, 32'h0);
        xact(30'h400, 1, 32'hFFFFFFFF, 4'hF, 0, 1, rd, er, lat);
        check("oor_write_err", er, 1);
        xact(30'd0, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("oor_no_alias", rd, init0);
        check("oor_no_alias_err", er, 0);

        xact(30'd5, 1, 32'h0, 4'h0, 0, 1, rd, er, lat);
        xact(30'd5, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("mask0_unchanged", rd, 32'hDEADBEEF);

        resp_ready = 1;
        issue(30'd7, 1, 32'h12345678, 4'hF);
        apply_reset();
        repeat (4) @(negedge clk);
        xact(30'd7, 0, 32'h0, 4'h0, 0, 1, rd, er, lat);
        check("rd7_after_reset", rd, 32'h0);

        resp_ready = 0;
        issue(30'd5, 0, 32'h0, 4'h0);
        k = 0;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("resp_before_reset", resp_valid, 1);
        apply_reset();

        repeat (150) begin
            logic [29:0] a;
            int          bp;
            a  = ($urandom_range(0, 9) < 8) ? 30'($urandom_range(0, 15))
                                             : (30'($urandom) | 30'h400);
            bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            xact(a, 1'($urandom), $urandom, 4'($urandom), bp, 1'($urandom), rd, er, lat);
        end

        // LATENCY=0 instance, requests held back to back: accepts land on edges
        // 1, 4, 7 (a write, then reads), responses show on edges 2, 5, 8.
        z_req_valid = 1; z_req_we = 1; z_req_addr = 30'd9; z_req_wdata = 32'hCAFEF00D;
        z_req_wmask = 4'hF; z_resp_ready = 1;
        @(negedge clk);
        z_reset = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("z_req_ready", z_req_ready, 32'(j % 3 == 0));
            check("z_resp_valid", z_resp_valid, 32'(j % 3 == 2));
            check("z_resp_rdata", z_resp_rdata,
                  (j % 3 == 2 && j > 2) ? 32'hCAFEF00D : 32'h0);
            check("z_resp_err", z_resp_err, 0);
            if (j == 1) begin
                z_req_we = 0; z_req_wdata = 32'h0BADF00D; z_req_wmask = 4'h0;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the CPU memory port: accepts word-addressed read/write requests from the fetch/load-store side of `cpu` over a valid/ready handshake and returns exactly one response per request, also valid/ready. Backs the requests with an internal synchronous word array, with a configurable number of wait states to model slower memory. It replaces the always-ready `ram` hookup once the `control` stepping logic waits on memory rather than assuming fixed one-cycle reads.

## Interface
- `ADDR_WIDTH`, 10, log2 of array depth in 32-bit words (1024 words).
- `LATENCY`, 2, wait-state cycles inserted before the array access; legal range 0..15.
- `clk` input 1, the single clock; all state updates on its rising edge.
- `reset` input 1, asynchronous, active-high.
- `req_valid` input 1, request present.
- `req_ready` output 1, responder can accept a request this cycle.
- `req_addr` input 30, word address (CPU byte address bits [31:2]).
- `req_we` input 1, 1 = write, 0 = read.
- `req_wdata` input 32, write data.
- `req_wmask` input 4, byte-lane write enables; bit i controls bits [8i+7:8i]; ignored on reads.
- `resp_valid` output 1, response present.
- `resp_ready` input 1, requester accepts response.
- `resp_rdata` output 32, read data; 0 for writes and errors.
- `resp_err` output 1, address out of range.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready` at an edge, latch addr, we, wdata, wmask. Go to WAIT with counter=LATENCY, or to ACCESS if LATENCY=0.
- WAIT: `req_ready`=0. Decrement counter each edge. Go to ACCESS on the edge where the counter goes 1->0.
- ACCESS: one cycle.
  - In range (`addr[29:ADDR_WIDTH]`==0), read: register the array word into `resp_rdata`.
  - In range, write: update only the masked bytes; `resp_rdata`=0. A write with mask 0 changes nothing but still responds.
  - Out of range: no array access; `resp_err`=1, `resp_rdata`=0.
  - Go to RESP.
- RESP: `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until `resp_valid & resp_ready` at an edge. On that edge go to IDLE and clear `resp_valid`, `resp_err` and `resp_rdata` to 0.
- Input changes while not in IDLE are ignored; latched values are used.
- Array contents are not reset and are unknown until written.

## Timing
- Reset asserted, asynchronous:
  - state=IDLE, counter=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready`=0 while reset is high, 1 from the first cycle after deassertion.
- Reset mid-operation (WAIT, ACCESS or RESP): the transaction is dropped and no response is issued. A write that has not reached its ACCESS cycle does not modify the array. A write whose ACCESS edge has completed stays committed.
- Latency: request accepted at edge N gives `resp_valid` high from edge N+LATENCY+1, i.e. the first sample at edge N+LATENCY+2. With LATENCY=0, `resp_valid` rises after edge N+1.
- `resp_valid` stays high indefinitely while `resp_ready`=0 (backpressure); nothing is lost.
- If `resp_ready` is already high when `resp_valid` rises, the handshake completes at the next edge.
- `req_ready` rises the cycle after the response handshake. No overlap: minimum request spacing is LATENCY+3 cycles.
- `req_ready` is a registered function of state only, with no combinational path from `req_valid`. `resp_valid` is registered.

## Test plan
- Reset then idle: assert `reset` mid-cycle -> `resp_valid`=0, `resp_rdata`=0, `resp_err`=0 immediately. After release, `req_ready`=1 next cycle.
- LATENCY=2, write addr 5 data 0xDEADBEEF mask 4'b1111, then read addr 5 with `resp_ready`=1:
  - Each `resp_valid` appears exactly 3 cycles after its accept edge.
  - Read returns 0xDEADBEEF, `resp_err`=0.
  - Write response has `resp_rdata`=0.
- Byte masking: write 0x11223344 mask 4'b1111, then 0xAABBCCDD mask 4'b0101, then read -> 0x11BB33DD.
- Backpressure: read with `resp_ready`=0 for 10 cycles:
  - `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0 throughout.
  - Raise `resp_ready` -> handshake next edge, `req_ready`=1 the following cycle.
- Out of range with ADDR_WIDTH=10:
  - Read addr 0x400 -> `resp_err`=1, `resp_rdata`=0.
  - Write addr 0x400 wraps to nothing: addr 0 contents unchanged.
- Reset mid-WAIT during write to addr 7 (previously 0x0) -> no response issued; a subsequent read of addr 7 returns 0x0. Repeat with LATENCY=0 for back-to-back reads, spacing exactly 3 cycles.
